// File: rtl/multi7_display_arbiter_pkg.sv
// Shared types and constants for the two-client seven-segment display arbiter.
package multi7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_HANDOFF = 2'd2
    } arb_state_t;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;
    localparam int         NUM_CLIENTS = 2;

endpackage

// File: rtl/multi7_display_arbiter_if.sv
// Client-facing request/write bus of the display arbiter.
// Handshake: a frame moves on a clock edge where i_wr_valid[n] and o_wr_ready[n] are both high;
// the client holds valid and data stable until then, and ready never depends on valid.
interface multi7_display_arbiter_if #(
    parameter int DIGITS = 4
);
    import multi7_pkg::*;

    logic [NUM_CLIENTS-1:0]          i_req;
    logic [NUM_CLIENTS-1:0]          i_wr_valid;
    logic [NUM_CLIENTS*DIGITS*4-1:0] i_wr_data;
    logic [NUM_CLIENTS-1:0]          o_wr_ready;
    logic [NUM_CLIENTS-1:0]          o_grant;
    logic [DIGITS*4-1:0]             o_digits;

    modport master (
        output i_req, i_wr_valid, i_wr_data,
        input  o_wr_ready, o_grant, o_digits
    );

    modport slave (
        input  i_req, i_wr_valid, i_wr_data,
        output o_wr_ready, o_grant, o_digits
    );

endinterface

// File: rtl/multi7_display_arbiter_rr_pick2.sv
// Two-way round-robin picker: holds the most recently granted client and picks the winner.
module multi7_rr_pick2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       winner
);

    logic last;

    // With no request the winner is unused by the caller; client 0 is a harmless default.
    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (update) begin
            last <= winner;
        end
    end

endmodule

// File: rtl/multi7_display_arbiter.sv
// Round-robin owner of the multi7 display with a minimum hold time per grant.
// Define MULTI7_ARB_BLANK_ON_IDLE_EN to blank the display on every entry into IDLE.
module multi7_display_arbiter
    import multi7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int HOLD_TICKS = 10000
) (
    input  logic                     i_clk_10mhz,
    input  logic                     i_rst,
    multi7_display_arbiter_if.slave  bus,
    output arb_state_t               dbg_state
);

    localparam int CW = $clog2(HOLD_TICKS + 1);
    localparam int FW = DIGITS * 4;

    arb_state_t          state, state_next;
    logic                owner, owner_next;
    logic [CW-1:0]       cnt, cnt_next;
    logic [1:0]          grant_q, grant_next;
    logic [FW-1:0]       digits_q, digits_next;
    logic                winner;
    logic                pick_update;
    logic                other;
    logic                hold_done;
    logic [1:0]          accept;

    multi7_rr_pick2 u_pick (
        .clk    (i_clk_10mhz),
        .rst    (i_rst),
        .req    (bus.i_req),
        .update (pick_update),
        .winner (winner)
    );

    assign other     = ~owner;
    assign hold_done = (cnt == CW'(HOLD_TICKS));
    assign accept    = bus.i_wr_valid & grant_q;

    // A fresh grant loads 1 so the counter equals the number of cycles owned so far.
    always_comb begin
        state_next  = state;
        owner_next  = owner;
        cnt_next    = cnt;
        pick_update = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (|bus.i_req) begin
                    state_next  = ST_ACTIVE;
                    owner_next  = winner;
                    pick_update = 1'b1;
                    cnt_next    = CW'(1);
                end
            end
            ST_ACTIVE: begin
                if (!hold_done) begin
                    cnt_next = cnt + CW'(1);
                end
                if (!bus.i_req[owner]) begin
                    state_next = ST_IDLE;
                end else if (hold_done && bus.i_req[other]) begin
                    state_next = ST_HANDOFF;
                end
            end
            ST_HANDOFF: begin
                cnt_next = '0;
                if (bus.i_req[other]) begin
                    state_next  = ST_ACTIVE;
                    owner_next  = winner;
                    pick_update = 1'b1;
                    cnt_next    = CW'(1);
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        grant_next = 2'b00;
        if (state_next == ST_ACTIVE) begin
            grant_next = owner_next ? 2'b10 : 2'b01;
        end
    end

    // A write on the edge that leaves ACTIVE still wins over blanking.
    always_comb begin
        digits_next = digits_q;
        if (accept[1]) begin
            digits_next = bus.i_wr_data[FW +: FW];
        end else if (accept[0]) begin
            digits_next = bus.i_wr_data[0 +: FW];
        end
`ifdef MULTI7_ARB_BLANK_ON_IDLE_EN
        else if (state_next == ST_IDLE && state != ST_IDLE) begin
            digits_next = {DIGITS{BLANK_DIGIT}};
        end
`endif
    end

    always_ff @(posedge i_clk_10mhz) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            owner    <= 1'b0;
            cnt      <= '0;
            grant_q  <= 2'b00;
            digits_q <= {DIGITS{BLANK_DIGIT}};
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            cnt      <= cnt_next;
            grant_q  <= grant_next;
            digits_q <= digits_next;
        end
    end

    assign bus.o_grant    = grant_q;
    assign bus.o_wr_ready = grant_q;
    assign bus.o_digits   = digits_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_multi7_display_arbiter.sv
// Directed bench for multi7_display_arbiter with a cycle-level ownership model and literal checkpoints.
module tb_multi7_display_arbiter;
    import multi7_pkg::*;

    localparam int HOLD = 4;
`ifdef MULTI7_ARB_BLANK_ON_IDLE_EN
    localparam bit BLANK_ON_IDLE = 1'b1;
`else
    localparam bit BLANK_ON_IDLE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    arb_state_t dbg_state;
    int         n_vec = 0;
    int         n_err = 0;

    multi7_display_arbiter_if #(.DIGITS(4)) bus();

    multi7_display_arbiter #(.DIGITS(4), .HOLD_TICKS(HOLD)) dut (
        .i_clk_10mhz (clk),
        .i_rst       (rst),
        .bus         (bus),
        .dbg_state   (dbg_state)
    );

    always #50 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner is -1 when nobody owns; gap marks the one-cycle handoff; held counts owned cycles.
    int          m_owner = -1;
    bit          m_gap   = 1'b0;
    int          m_last  = 1;
    int          m_held  = 0;
    logic [15:0] m_digits = 16'hFFFF;

    always @(posedge clk) begin
        logic [1:0] r;
        bit         wrote;
        int         prev;
        r = bus.i_req;
        if (rst) begin
            m_owner  = -1;
            m_gap    = 1'b0;
            m_last   = 1;
            m_held   = 0;
            m_digits = 16'hFFFF;
        end else begin
            wrote = 1'b0;
            if (m_owner >= 0 && !m_gap && bus.i_wr_valid[m_owner]) begin
                m_digits = bus.i_wr_data[m_owner*16 +: 16];
                wrote    = 1'b1;
            end
            if (m_gap) begin
                m_gap = 1'b0;
                prev  = m_owner;
                if (r[1-prev]) begin
                    m_owner = 1 - prev;
                    m_last  = m_owner;
                    m_held  = 1;
                end else begin
                    m_owner = -1;
                    if (BLANK_ON_IDLE) m_digits = 16'hFFFF;
                end
            end else if (m_owner < 0) begin
                if (r != 2'b00) begin
                    m_owner = (r == 2'b11) ? 1 - m_last : (r[0] ? 0 : 1);
                    m_last  = m_owner;
                    m_held  = 1;
                end
            end else if (!r[m_owner]) begin
                m_owner = -1;
                if (BLANK_ON_IDLE && !wrote) m_digits = 16'hFFFF;
            end else if (m_held >= HOLD && r[1-m_owner]) begin
                m_gap = 1'b1;
            end else begin
                m_held++;
            end
        end
    end

    function automatic logic [1:0] m_grant();
        if (m_owner >= 0 && !m_gap) return (m_owner == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        chk("cyc_grant", 32'(bus.o_grant), 32'(m_grant()));
        chk("cyc_ready", 32'(bus.o_wr_ready), 32'(m_grant()));
        chk("cyc_digits", 32'(bus.o_digits), 32'(m_digits));
    end

    task automatic step();
        @(posedge clk);
        #10;
    endtask

    task automatic wr(input logic [1:0] valid, input logic [15:0] d1, input logic [15:0] d0);
        bus.i_wr_valid = valid;
        bus.i_wr_data  = {d1, d0};
    endtask

    initial begin
        rst            = 1'b1;
        bus.i_req      = 2'b00;
        bus.i_wr_valid = 2'b00;
        bus.i_wr_data  = '0;
        step();
        step();
        chk("rst_digits", 32'(bus.o_digits), 32'h0000FFFF);
        chk("rst_grant", 32'(bus.o_grant), 32'h0);
        chk("rst_ready", 32'(bus.o_wr_ready), 32'h0);
        rst = 1'b0;

        // Client 0 alone, one frame, then release before the hold expires
        bus.i_req = 2'b01;
        step();
        chk("a_grant", 32'(bus.o_grant), 32'h1);
        wr(2'b01, 16'h0000, 16'h1234);
        step();
        chk("a_digits", 32'(bus.o_digits), 32'h1234);
        wr(2'b00, 16'h0000, 16'h0000);
        bus.i_req = 2'b00;
        step();
        chk("a_release_grant", 32'(bus.o_grant), 32'h0);
        chk("a_release_digits", 32'(bus.o_digits), BLANK_ON_IDLE ? 32'hFFFF : 32'h1234);

        // Both clients from reset: client 0 first, 4 owned cycles, 1 gap, then client 1
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("b_rst_digits", 32'(bus.o_digits), 32'hFFFF);
        bus.i_req = 2'b11;
        step();
        chk("b_grant0", 32'(bus.o_grant), 32'h1);
        step();
        step();
        step();
        chk("b_grant0_held", 32'(bus.o_grant), 32'h1);
        step();
        chk("b_handoff_grant", 32'(bus.o_grant), 32'h0);
        chk("b_handoff_ready", 32'(bus.o_wr_ready), 32'h0);
        step();
        chk("b_grant1", 32'(bus.o_grant), 32'h2);
        chk("b_ready1", 32'(bus.o_wr_ready), 32'h2);

        // Client 1 owns: its frame lands, client 0's is ignored
        wr(2'b10, 16'h5678, 16'hAAAA);
        step();
        chk("c_digits", 32'(bus.o_digits), 32'h5678);
        wr(2'b01, 16'h0000, 16'hBBBB);
        step();
        chk("c_ignored", 32'(bus.o_digits), 32'h5678);
        wr(2'b00, 16'h0000, 16'h0000);
        step();
        step();
        chk("c_handoff", 32'(bus.o_grant), 32'h0);
        step();
        chk("c_back_to0", 32'(bus.o_grant), 32'h1);

        // Client 1 writes while client 0 owns
        wr(2'b10, 16'h9999, 16'h0000);
        step();
        chk("d_ready", 32'(bus.o_wr_ready), 32'h1);
        chk("d_digits", 32'(bus.o_digits), 32'h5678);
        wr(2'b00, 16'h0000, 16'h0000);

        // Owner drops while the other requests: one IDLE cycle, then the other
        bus.i_req = 2'b10;
        step();
        chk("e_idle", 32'(bus.o_grant), 32'h0);
        step();
        chk("e_grant1", 32'(bus.o_grant), 32'h2);

        // Write on the edge that leaves ACTIVE
        wr(2'b10, 16'h0042, 16'h0000);
        bus.i_req = 2'b00;
        step();
        chk("f_grant", 32'(bus.o_grant), 32'h0);
        chk("f_digits", 32'(bus.o_digits), 32'h0042);
        wr(2'b00, 16'h0000, 16'h0000);

        // Reset during ACTIVE with a write in flight
        bus.i_req = 2'b01;
        step();
        chk("g_grant", 32'(bus.o_grant), 32'h1);
        wr(2'b01, 16'h0000, 16'h4321);
        rst = 1'b1;
        step();
        chk("g_digits", 32'(bus.o_digits), 32'hFFFF);
        chk("g_grant_rst", 32'(bus.o_grant), 32'h0);
        chk("g_ready_rst", 32'(bus.o_wr_ready), 32'h0);
        rst = 1'b0;
        wr(2'b00, 16'h0000, 16'h0000);
        bus.i_req = 2'b00;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
